if_fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns PC_F, drives the instruction-memory request handshake
//  and the IF/ID pipeline register (instr_D, pc_D, pc4_D). Consumes the next-PC value produced by the
//  ID-stage PC calculator. Delay-slot semantics: the instruction after a branch/jump always executes.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 55 +++++
 rtl/if_fetch_stage.sv | 194 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: reset vector, bubble encoding,
// fetch FSM states and a word-alignment helper.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          IM_WORDS_DEFAULT = 1024;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Clears the byte-offset bits so a target always names a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds while stalled, can load a nop bubble, and
// otherwise captures the fetched instruction with its PC and PC+4.
// FETCH_ALIGN_CHECK_EN adds the address-error flag that travels with the entry.
module if_id_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
`ifdef FETCH_ALIGN_CHECK_EN
    input  logic        exc_in,
    output logic        exc_D,
`endif
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        valid_in,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        valid_D
);

    // Register update: reset clears, load without bubble captures, bubble inserts a nop.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_D <= NOP_INSTR;
            pc_D    <= 32'h0;
            pc4_D   <= 32'h0;
            valid_D <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            exc_D   <= 1'b0;
`endif
        end else if (load) begin
            if (bubble) begin
                instr_D <= NOP_INSTR;
                pc_D    <= 32'h0;
                pc4_D   <= 32'h0;
                valid_D <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                exc_D   <= 1'b0;
`endif
            end else begin
                instr_D <= instr_in;
                pc_D    <= pc_in;
                pc4_D   <= pc_in + 32'd4;
                valid_D <= valid_in;
`ifdef FETCH_ALIGN_CHECK_EN
                exc_D   <= exc_in;
`endif
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns PC_F, runs the instruction-memory
// request handshake and feeds the IF/ID register. A branch/jump seen while a
// fetch is still waiting is parked in a redirect buffer so the in-flight fetch
// (the delay slot) completes first.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned / out-of-range
// targets are not fetched and raise exc_adel_D instead).
module if_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_sel,
    input  logic [31:0] next_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        exc_adel_D,
`endif
    output logic        valid_D
);

    fetch_state_t state, state_nxt;

    logic [31:0] pc_f;
    logic [31:0] pc_plus4;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redir_pending;
    logic [31:0] redir_buf;
    logic [31:0] skid_word;

    logic        pc_load;
    logic        skid_load;
    logic        redir_set;
    logic        redir_clr;
    logic        if_load;
    logic        if_bubble;
    logic [31:0] if_instr;
    logic        if_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] PC_LAST = RESET_PC + 32'(IM_WORDS * 4 - 4);
    logic fetch_bad;
    logic if_exc;
`endif

    // Next fetch address: a parked redirect wins, then a live branch/jump, then sequential.
    always_comb begin
        pc_plus4   = pc_f + 32'd4;
        target_raw = redir_pending ? redir_buf : (pc_sel ? next_pc : pc_plus4);
`ifdef FETCH_ALIGN_CHECK_EN
        target     = target_raw;
        fetch_bad  = (pc_f[1:0] != 2'b00) || (pc_f < RESET_PC) || (pc_f > PC_LAST);
`else
        target     = word_align(target_raw);
`endif
    end

    // Fetch FSM next state and per-cycle control for PC_F, skid, redirect and IF/ID.
    always_comb begin
        state_nxt = state;
        im_req    = 1'b0;
        pc_load   = 1'b0;
        skid_load = 1'b0;
        redir_set = 1'b0;
        redir_clr = 1'b0;
        if_load   = 1'b0;
        if_bubble = 1'b0;
        if_instr  = NOP_INSTR;
        if_valid  = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        if_exc    = 1'b0;
`endif
        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (fetch_bad) begin
                    if (!stall) begin
                        if_load   = 1'b1;
                        if_valid  = 1'b0;
                        if_exc    = 1'b1;
                        pc_load   = 1'b1;
                        redir_clr = 1'b1;
                    end
                end else
`endif
                begin
                    im_req = 1'b1;
                    if (im_ready) begin
                        if (!stall) begin
                            if_load   = 1'b1;
                            if_instr  = im_rdata;
                            pc_load   = 1'b1;
                            redir_clr = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                            state_nxt = HOLD;
                        end
                    end else if (!stall) begin
                        if_load   = 1'b1;
                        if_bubble = 1'b1;
                        redir_set = pc_sel;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    if_load   = 1'b1;
                    if_instr  = skid_word;
                    pc_load   = 1'b1;
                    redir_clr = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign im_addr = pc_f;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC_F advances only when the current fetch is handed to IF/ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (pc_load) begin
            pc_f <= target;
        end
    end

    // Skid register keeps a word that returned while the pipeline was stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_word <= NOP_INSTR;
        end else if (skid_load) begin
            skid_word <= im_rdata;
        end
    end

    // Redirect buffer parks a branch target until the delay-slot fetch completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            redir_pending <= 1'b0;
            redir_buf     <= 32'h0;
        end else if (redir_set) begin
            redir_pending <= 1'b1;
            redir_buf     <= next_pc;
        end else if (redir_clr) begin
            redir_pending <= 1'b0;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
`ifdef FETCH_ALIGN_CHECK_EN
        .exc_in   (if_exc),
        .exc_D    (exc_adel_D),
`endif
        .load     (if_load),
        .bubble   (if_bubble),
        .instr_in (if_instr),
        .pc_in    (pc_f),
        .valid_in (if_valid),
        .instr_D  (instr_D),
        .pc_D     (pc_D),
        .pc4_D    (pc4_D),
        .valid_D  (valid_D)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a per-cycle vector table drives the
// fetch side, a scoreboard queue checks every instruction entering IF/ID, and
// hand-written sequences cover stall/skid, reset mid-fetch and target handling.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pc_sel;
    logic [31:0] next_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc4_D;
    logic        valid_D;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        exc_adel_D;
`endif

    int checks;
    int errors;

    typedef struct {
        bit          do_reset;
        bit          stall;
        bit          pc_sel;
        logic [31:0] next_pc;
        int          lat;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          chk_valid;
        bit          exp_valid;
        bit          push;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    int  mem_lat;
    int  wait_cnt;
    bit  mon_load;
    bit  bad_req_seen;

    if_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .pc_sel     (pc_sel),
        .next_pc    (next_pc),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ready   (im_ready),
        .im_rdata   (im_rdata),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .pc4_D      (pc4_D),
`ifdef FETCH_ALIGN_CHECK_EN
        .exc_adel_D (exc_adel_D),
`endif
        .valid_D    (valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hC000_0000 | a;
    endfunction

    // Memory model: answers after mem_lat waiting cycles, word derived from address.
    assign im_ready = im_req && (wait_cnt >= mem_lat);
    assign im_rdata = memWord(im_addr);

    always @(posedge clk) begin
        if (reset || !im_req || im_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (im_req && (im_addr[1:0] != 2'b00)) bad_req_seen <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic pushExp(input logic [31:0] addr);
        exp_t e;
        e.instr = memWord(addr);
        e.pc    = addr;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every valid entry loaded into IF/ID must match the next expected fetch.
    always @(posedge clk) begin
        mon_load = !stall && !reset;
        #1;
        if (mon_load && valid_D && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("sb_instr", instr_D, e.instr);
            checkOutput("sb_pc", pc_D, e.pc);
            checkOutput("sb_pc4", pc4_D, e.pc + 32'd4);
        end
    end

    task automatic waitDrain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic doReset();
        waitDrain();
        reset   = 1'b1;
        stall   = 1'b0;
        pc_sel  = 1'b0;
        next_pc = 32'h0;
        mem_lat = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_instr_D", instr_D, 32'h0);
        checkOutput("rst_pc_D", pc_D, 32'h0);
        checkOutput("rst_pc4_D", pc4_D, 32'h0);
        checkOutput("rst_valid_D", {31'h0, valid_D}, 32'h0);
        checkOutput("rst_im_req", {31'h0, im_req}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("rst_exc", {31'h0, exc_adel_D}, 32'h0);
`endif
    endtask

    task automatic addRow(input bit r, input bit s, input bit p, input logic [31:0] np, input int lat,
                          input bit er, input logic [31:0] ea, input bit cv, input bit ev, input bit pu);
        vec_t v;
        v.do_reset = r; v.stall = s; v.pc_sel = p; v.next_pc = np; v.lat = lat;
        v.exp_req = er; v.exp_addr = ea; v.chk_valid = cv; v.exp_valid = ev; v.push = pu;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.do_reset) doReset();
        stall   = v.stall;
        pc_sel  = v.pc_sel;
        next_pc = v.next_pc;
        mem_lat = v.lat;
        #1;
        checkOutput($sformatf("row%0d_im_req", idx), {31'h0, im_req}, {31'h0, v.exp_req});
        if (v.exp_req) checkOutput($sformatf("row%0d_im_addr", idx), im_addr, v.exp_addr);
        if (v.chk_valid) checkOutput($sformatf("row%0d_valid_D", idx), {31'h0, valid_D}, {31'h0, v.exp_valid});
        if (v.push) pushExp(v.exp_addr);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        stall        = 1'b0;
        pc_sel       = 1'b0;
        next_pc      = 32'h0;
        mem_lat      = 0;
        bad_req_seen = 1'b0;

        // Sequential zero-wait fetch: one dead cycle, then one word per cycle.
        addRow(1, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0);
        addRow(0, 0, 0, 32'h0,    0, 1, 32'h3000, 1, 0, 1);
        addRow(0, 0, 0, 32'h0,    0, 1, 32'h3004, 1, 1, 1);
        addRow(0, 0, 0, 32'h0,    0, 1, 32'h3008, 1, 1, 1);
        // Branch taken while 0x3004 is being fetched.
        addRow(1, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0);
        addRow(0, 0, 0, 32'h0,    0, 1, 32'h3000, 0, 0, 1);
        addRow(0, 0, 1, 32'h3040, 0, 1, 32'h3004, 0, 0, 1);
        addRow(0, 0, 0, 32'h0,    0, 1, 32'h3040, 0, 0, 1);
        addRow(0, 0, 0, 32'h0,    0, 1, 32'h3044, 0, 0, 1);
        // Two wait cycles with a branch during the wait: delay slot first, bubbles meanwhile.
        addRow(1, 0, 0, 32'h0,    2, 0, 32'h0,    0, 0, 0);
        addRow(0, 0, 1, 32'h3040, 2, 1, 32'h3000, 0, 0, 0);
        addRow(0, 0, 0, 32'h0,    2, 1, 32'h3000, 1, 0, 0);
        addRow(0, 0, 0, 32'h0,    2, 1, 32'h3000, 1, 0, 1);
        addRow(0, 0, 0, 32'h0,    0, 1, 32'h3040, 1, 1, 1);
        addRow(0, 0, 0, 32'h0,    0, 1, 32'h3044, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);

        // Stall coincident with a returning word: skid, frozen IF/ID, release without loss or dup.
        doReset();
        @(negedge clk); #1;
        checkOutput("stl_addr0", im_addr, 32'h3000);
        pushExp(32'h3000);
        @(negedge clk);
        stall = 1'b1; #1;
        checkOutput("stl_addr1", im_addr, 32'h3004);
        checkOutput("stl_req1", {31'h0, im_req}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checkOutput("stl_hold_req", {31'h0, im_req}, 32'h0);
            checkOutput("stl_hold_instr", instr_D, memWord(32'h3000));
            checkOutput("stl_hold_valid", {31'h0, valid_D}, 32'h1);
        end
        @(negedge clk);
        stall = 1'b0; #1;
        checkOutput("stl_rel_req", {31'h0, im_req}, 32'h0);
        checkOutput("stl_rel_instr", instr_D, memWord(32'h3000));
        pushExp(32'h3004);
        @(negedge clk); #1;
        checkOutput("stl_next_addr", im_addr, 32'h3008);
        checkOutput("stl_next_req", {31'h0, im_req}, 32'h1);
        pushExp(32'h3008);
        @(negedge clk);

        // Reset while a fetch waits with a parked redirect: restart at the reset vector.
        doReset();
        mem_lat = 3;
        @(negedge clk);
        pc_sel = 1'b1; next_pc = 32'h3080; #1;
        checkOutput("rmid_addr0", im_addr, 32'h3000);
        @(negedge clk);
        pc_sel = 1'b0; reset = 1'b1; #1;
        checkOutput("rmid_req_wait", {31'h0, im_req}, 32'h1);
        @(negedge clk);
        reset = 1'b0; mem_lat = 0; #1;
        checkOutput("rmid_req_dropped", {31'h0, im_req}, 32'h0);
        @(negedge clk); #1;
        checkOutput("rmid_addr_restart", im_addr, 32'h3000);
        pushExp(32'h3000);
        @(negedge clk); #1;
        checkOutput("rmid_no_redirect", im_addr, 32'h3004);
        pushExp(32'h3004);
        @(negedge clk);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned target is not fetched and produces an address-error entry.
        doReset();
        @(negedge clk); #1;
        checkOutput("aln_addr0", im_addr, 32'h3000);
        pushExp(32'h3000);
        @(negedge clk);
        pc_sel = 1'b1; next_pc = 32'h3042; #1;
        checkOutput("aln_addr1", im_addr, 32'h3004);
        pushExp(32'h3004);
        @(negedge clk);
        pc_sel = 1'b0; #1;
        checkOutput("aln_no_req", {31'h0, im_req}, 32'h0);
        @(negedge clk); #1;
        checkOutput("aln_exc", {31'h0, exc_adel_D}, 32'h1);
        checkOutput("aln_valid", {31'h0, valid_D}, 32'h0);
        checkOutput("aln_pc_D", pc_D, 32'h3042);
        checkOutput("aln_instr", instr_D, 32'h0);
`else
        // Target low bits are dropped, and a target at the top of memory wraps to zero.
        doReset();
        @(negedge clk); #1;
        checkOutput("aln_addr0", im_addr, 32'h3000);
        pushExp(32'h3000);
        @(negedge clk);
        pc_sel = 1'b1; next_pc = 32'h3043; #1;
        checkOutput("aln_addr1", im_addr, 32'h3004);
        pushExp(32'h3004);
        @(negedge clk);
        next_pc = 32'hFFFF_FFFC; #1;
        checkOutput("aln_forced", im_addr, 32'h3040);
        pushExp(32'h3040);
        @(negedge clk);
        pc_sel = 1'b0; #1;
        checkOutput("wrap_top", im_addr, 32'hFFFF_FFFC);
        pushExp(32'hFFFF_FFFC);
        @(negedge clk); #1;
        checkOutput("wrap_zero", im_addr, 32'h0000_0000);
        pushExp(32'h0000_0000);
        @(negedge clk);
`endif

        waitDrain();
        checkOutput("no_misaligned_req", {31'h0, bad_req_seen}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
